// File: rtl/frame_minmax_tracker.sv
// Streaming per-frame extrema: reduces every FRAME_LEN accepted samples to their max and min,
// then holds the pair on a valid/ready output until the consumer takes it.
//
// state | meaning
// IDLE  | no samples of a frame held, ready for the first one
// ACCUM | part of a frame accepted, folding further samples into max/min
// HOLD  | frame complete, result presented until taken; input stalled
module frame_minmax_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic             busy
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_count_inc;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] w_max_nxt;
    logic [WIDTH-1:0] w_min_nxt;
    logic             w_accept;
    logic             w_take;

    // in_ready depends on registered state only, never on out_ready
    assign in_ready    = (r_state != HOLD);
    assign out_valid   = (r_state == HOLD);
    assign busy        = (r_state != IDLE);
    assign out_max     = r_max;
    assign out_min     = r_min;
    assign w_accept    = in_valid && in_ready;
    assign w_take      = out_valid && out_ready;
    assign w_count_inc = r_count + CW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_max_nxt   = r_max;
        w_min_nxt   = r_min;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_max_nxt   = in_data;
                    w_min_nxt   = in_data;
                    w_count_nxt = CW'(1);
                    w_state_nxt = (FRAME_LEN == 1) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    if (in_data > r_max) w_max_nxt = in_data;
                    if (in_data < r_min) w_min_nxt = in_data;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == LAST) w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_take) begin
                    w_state_nxt = IDLE;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_max   <= '0;
            r_min   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_max   <= w_max_nxt;
            r_min   <= w_min_nxt;
        end
    end

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Bench for frame_minmax_tracker: a FRAME_LEN=4 and a FRAME_LEN=1 instance checked every cycle
// against a frame-collecting model, plus directed literal expectations.
module tb_frame_minmax_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b1;
    logic [1:0]      iv, ir, ov, ord, bz;
    logic [1:0][7:0] id, omax, omin;

    frame_minmax_tracker #(.WIDTH(8), .FRAME_LEN(4)) u_fl4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ord[0]),
        .out_max(omax[0]), .out_min(omin[0]), .busy(bz[0])
    );

    frame_minmax_tracker #(.WIDTH(8), .FRAME_LEN(1)) u_fl1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ord[1]),
        .out_max(omax[1]), .out_min(omin[1]), .busy(bz[1])
    );

    int pass_n  = 0;
    int total_n = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    endtask

    function automatic int fl(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Model: collect the accepted samples of a frame, reduce them when the frame is full.
    bit m_hold[2];
    bit m_fresh[2];
    int m_cnt[2];
    int m_max[2];
    int m_min[2];
    int smp[2][256];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_hold[d]  = 1'b0;
                m_fresh[d] = 1'b1;
                m_cnt[d]   = 0;
                m_max[d]   = 0;
                m_min[d]   = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_hold[d]) begin
                    if (ord[d]) m_hold[d] = 1'b0;
                end else if (iv[d]) begin
                    m_fresh[d] = 1'b0;
                    smp[d][m_cnt[d]] = int'(id[d]);
                    m_cnt[d]++;
                    if (m_cnt[d] == fl(d)) begin
                        m_max[d] = 0;
                        m_min[d] = 255;
                        for (int k = 0; k < m_cnt[d]; k++) begin
                            if (smp[d][k] > m_max[d]) m_max[d] = smp[d][k];
                            if (smp[d][k] < m_min[d]) m_min[d] = smp[d][k];
                        end
                        m_cnt[d]  = 0;
                        m_hold[d] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_in_ready", d), int'(ir[d]), int'(!m_hold[d]));
            chk($sformatf("d%0d_out_valid", d), int'(ov[d]), int'(m_hold[d]));
            chk($sformatf("d%0d_busy", d), int'(bz[d]), int'(m_hold[d] || (m_cnt[d] > 0)));
            if (m_hold[d] || m_fresh[d]) begin
                chk($sformatf("d%0d_out_max", d), int'(omax[d]), m_max[d]);
                chk($sformatf("d%0d_out_min", d), int'(omin[d]), m_min[d]);
            end
        end
    end

    // One cycle of stimulus on instance d; the other instance idles with out_ready high.
    task automatic cyc(input int d, input bit v, input int data, input bit r);
        iv[d]    = v;
        id[d]    = 8'(data);
        ord[d]   = r;
        iv[1-d]  = 1'b0;
        ord[1-d] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input int a, input int b, input int c, input int e, input bit r);
        cyc(0, 1'b1, a, r);
        cyc(0, 1'b1, b, r);
        cyc(0, 1'b1, c, r);
        cyc(0, 1'b1, e, r);
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = '0;
        ord   = '1;
        id    = '0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(ir[0]), 1);
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_out_max", int'(omax[0]), 0);
        chk("rst_out_min", int'(omin[0]), 0);

        frame4(12, 200, 7, 90, 1'b1);
        chk("f1_out_valid", int'(ov[0]), 1);
        chk("f1_out_max", int'(omax[0]), 200);
        chk("f1_out_min", int'(omin[0]), 7);
        chk("f1_model_max", m_max[0], 200);
        cyc(0, 1'b0, 0, 1'b1);
        chk("f1_valid_one_cycle", int'(ov[0]), 0);

        frame4(8'h55, 8'h55, 8'h55, 8'h55, 1'b1);
        chk("eq_out_max", int'(omax[0]), 8'h55);
        chk("eq_out_min", int'(omin[0]), 8'h55);
        cyc(0, 1'b0, 0, 1'b1);

        frame4(0, 255, 255, 0, 1'b1);
        chk("ext_out_max", int'(omax[0]), 255);
        chk("ext_out_min", int'(omin[0]), 0);
        cyc(0, 1'b0, 0, 1'b1);

        frame4(3, 1, 4, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1'b1, 99, 1'b0);
            chk("bp_out_valid", int'(ov[0]), 1);
            chk("bp_out_max", int'(omax[0]), 4);
            chk("bp_out_min", int'(omin[0]), 1);
            chk("bp_in_ready", int'(ir[0]), 0);
        end
        cyc(0, 1'b0, 0, 1'b1);
        chk("bp_taken", int'(ov[0]), 0);
        chk("bp_ready_after_take", int'(ir[0]), 1);

        cyc(0, 1'b1, 9, 1'b1);
        cyc(0, 1'b0, 0, 1'b1);
        cyc(0, 1'b0, 0, 1'b1);
        cyc(0, 1'b1, 2, 1'b1);
        cyc(0, 1'b0, 0, 1'b1);
        cyc(0, 1'b1, 5, 1'b1);
        chk("gap_not_yet", int'(ov[0]), 0);
        cyc(0, 1'b1, 8, 1'b1);
        chk("gap_out_valid", int'(ov[0]), 1);
        chk("gap_out_max", int'(omax[0]), 9);
        chk("gap_out_min", int'(omin[0]), 2);
        cyc(0, 1'b0, 0, 1'b1);

        cyc(0, 1'b1, 100, 1'b1);
        cyc(0, 1'b1, 50, 1'b1);
        iv[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_max", int'(omax[0]), 0);
        chk("mid_rst_out_min", int'(omin[0]), 0);
        chk("mid_rst_busy", int'(bz[0]), 0);
        chk("mid_rst_out_valid", int'(ov[0]), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame4(10, 20, 30, 40, 1'b1);
        chk("post_rst_out_max", int'(omax[0]), 40);
        chk("post_rst_out_min", int'(omin[0]), 10);
        cyc(0, 1'b0, 0, 1'b1);

        cyc(1, 1'b1, 77, 1'b1);
        chk("fl1_a_valid", int'(ov[1]), 1);
        chk("fl1_a_max", int'(omax[1]), 77);
        chk("fl1_a_min", int'(omin[1]), 77);
        chk("fl1_a_in_ready", int'(ir[1]), 0);
        cyc(1, 1'b1, 3, 1'b1);
        chk("fl1_bubble_valid", int'(ov[1]), 0);
        chk("fl1_bubble_in_ready", int'(ir[1]), 1);
        cyc(1, 1'b1, 3, 1'b1);
        chk("fl1_b_valid", int'(ov[1]), 1);
        chk("fl1_b_max", int'(omax[1]), 3);
        chk("fl1_b_min", int'(omin[1]), 3);
        cyc(1, 1'b0, 0, 1'b1);
        chk("fl1_b_taken", int'(ov[1]), 0);

        repeat (3) cyc(0, 1'b0, 0, 1'b1);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/frame_minmax_tracker.md
Name: frame_minmax_tracker

Overview:
- Sequential streaming counterpart to the team's combinational max/min selector.
- Consumes a stream of unsigned samples over a valid/ready handshake and reduces each frame of FRAME_LEN samples to its maximum and minimum.
- Presents both results on a valid/ready output port.
- Sits between a sample producer and any downstream consumer that needs per-frame extrema, such as range checkers or auto-scaling logic.

Parameters:
WIDTH, 8, sample and result width in bits (unsigned)
FRAME_LEN, 4, samples per frame; legal range is 1 to 255

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample
in_data  input  WIDTH  sample value, unsigned
out_valid  output  1  frame result available
out_ready  input  1  downstream accepts result
out_max  output  WIDTH  largest sample in the completed frame
out_min  output  WIDTH  smallest sample in the completed frame
busy  output  1  at least one sample of the current frame accepted and result not yet taken

Behaviour:
- Reset is one clock; rst_n is asynchronous and active-low. Assertion at any time, including mid-frame or while holding a result:
  - state becomes IDLE, count becomes 0
  - out_valid=0, busy=0, out_max=0, out_min=0
  - in_ready=1 on the first cycle after deassertion
  - the partial frame is discarded; no result is produced for it.
- Accept: a sample is accepted on a rising edge where in_valid && in_ready. Result take: a result is taken on a rising edge where out_valid && out_ready.
- States:
  - IDLE: no samples held. in_ready=1.
    - On accept: max_r=min_r=in_data, count=1.
    - Next state is ACCUM, or HOLD if FRAME_LEN==1.
  - ACCUM: in_ready=1.
    - On accept: max_r=(in_data>max_r)?in_data:max_r and min_r=(in_data<min_r)?in_data:min_r, using strict unsigned compares. Ties leave the register unchanged, with no observable difference.
    - count increments. The accept that makes count==FRAME_LEN moves to HOLD, and its sample is included in the result.
  - HOLD: in_ready=0, out_valid=1, and out_max/out_min are stable.
    - On result take: go to IDLE and set count=0.
    - While out_ready=0, hold indefinitely with outputs unchanged.
- out_max/out_min are driven from max_r/min_r. Outside HOLD they are don't-care to consumers but must not be X after reset.
- Latency: out_valid rises on the cycle immediately after the edge that accepted the last sample of the frame.
- Throughput: one sample per cycle inside a frame. There is one bubble cycle per frame because in_ready=0 for at least the HOLD cycle.
  - in_ready is a registered-state function only. It has no combinational path from out_ready.
- Simultaneous events:
  - In HOLD, in_valid is ignored because in_ready=0.
  - A take in HOLD and a new sample cannot coincide. The next sample is accepted no earlier than the cycle after the take.
- busy=1 in ACCUM and HOLD, and also in IDLE→HOLD for FRAME_LEN==1. busy=0 in IDLE.
- Counter width is clog2(FRAME_LEN+1). The counter never exceeds FRAME_LEN and cannot wrap.
- in_valid held low mid-frame: state and registers hold with no timeout.
- All comparisons are unsigned. Values 0 and 2^WIDTH-1 are handled as ordinary samples.

Test Plan:
- Reset then frame 12,200,7,90, each with in_valid=1 and out_ready=1 → out_valid=1 exactly one cycle after the 4th accept, out_max=200, out_min=7, and out_valid is high for one cycle.
- All-equal frame 0x55 ×4 → out_max=0x55, out_min=0x55. Extremes frame 0,255,255,0 → out_max=255, out_min=0.
- Backpressure: complete frame 3,1,4,1 with out_ready=0 for 5 cycles → out_valid stays 1, outputs stay 4/1, in_ready=0 and in_valid pulses ignored. Raising out_ready gives a take, then in_ready=1 on the next cycle.
- Gapped input: frame 9,_,_,2,_,5,8 where _ means in_valid=0 → result max=9, min=2, produced only after the 4th accepted sample.
- Reset mid-frame: accept 100,50, pulse rst_n low asynchronously between edges → outputs go to zero immediately. A following frame 10,20,30,40 gives max=40, min=10 with no trace of 100/50.
- FRAME_LEN=1 build: samples 77 then 3 back-to-back with out_ready=1 → results 77/77 then 3/3, with in_ready low one cycle between them.
